// File: rtl/fetch_pkg.sv
// Shared constants and types for the decoupled instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT            = 32;
  localparam int unsigned DEPTH_DEFAULT           = 4;
  localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;
  localparam logic [31:0] RESET_PC_DEFAULT        = 32'h0000_0000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; head data is visible combinationally from storage.
// Push is written one cycle later; the caller guarantees no push-when-full or pop-when-empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-two depths work for the tag FIFO.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = bump(wr_ptr_q);
      if (pop_i)  rd_ptr_d = bump(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Decoupled fetch: issues word fetches to variable-latency memory and queues responses for Decode.
// Response to o_ValidF is one cycle; issue stops when queue slots are all reserved; i_StallD holds the head.
module prefetch_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEFAULT,
  parameter int unsigned     DEPTH           = DEPTH_DEFAULT,
  parameter int unsigned     MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  output logic            o_ReqValid,
  input  logic            i_ReqReady,
  output logic [XLEN-1:0] o_ReqAddr,
  input  logic            i_RspValid,
  input  logic [31:0]     i_RspData,
  input  logic            i_PCSrcE,
  input  logic [XLEN-1:0] i_PCTargetE,
  input  logic            i_StallD,
  output logic            o_ValidF,
  output logic [31:0]     o_InstrF,
  output logic [XLEN-1:0] o_PCF,
  output logic [XLEN-1:0] o_PCPlus4F
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned RES_W = $clog2(DEPTH + MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [INF_W-1:0] drop_q, drop_d;
  logic             run_q;
  logic [INF_W-1:0] inflight;
  logic [OCC_W-1:0] occ;
  logic [RES_W-1:0] reserved;
  logic [XLEN-1:0]  tag_pc;
  logic             fire, rsp_keep, pop;
  entry_t           head, push_entry;

  // Slots owed to live in-flight requests count against queue space at issue time.
  assign reserved   = RES_W'(inflight) - RES_W'(drop_q) + RES_W'(occ);
  assign o_ReqValid = run_q && !i_PCSrcE
                      && (inflight < INF_W'(MAX_OUTSTANDING))
                      && (reserved < RES_W'(DEPTH));
  assign o_ReqAddr  = fetch_pc_q;
  assign fire       = o_ReqValid && i_ReqReady;
  assign rsp_keep   = i_RspValid && (drop_q == '0) && !i_PCSrcE;
  assign pop        = o_ValidF && !i_StallD && !i_PCSrcE;
  assign push_entry = '{pc: tag_pc, instr: i_RspData};

  assign o_ValidF   = (occ != '0);
  assign o_InstrF   = o_ValidF ? head.instr : NOP;
  assign o_PCF      = o_ValidF ? head.pc : RESET_PC;
  assign o_PCPlus4F = o_PCF + XLEN'(4);

  always_comb begin
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (i_PCSrcE) begin
      drop_d     = inflight - INF_W'(i_RspValid);
      fetch_pc_d = i_PCTargetE & ~XLEN'(3);
    end else begin
      if (i_RspValid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  // Tag FIFO occupancy doubles as the in-flight request counter.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (i_Clk),
    .rst_ni     (i_Reset),
    .clear_i    (1'b0),
    .push_i     (fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (i_RspValid),
    .head_dat_o (tag_pc),
    .count_o    (inflight)
  );

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .clk_i      (i_Clk),
    .rst_ni     (i_Reset),
    .clear_i    (i_PCSrcE),
    .push_i     (rsp_keep),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (occ)
  );

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit with a latency-programmable memory model and an in-order scoreboard.
module tb_prefetch_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        o_ReqValid;
  logic        i_ReqReady;
  logic [31:0] o_ReqAddr;
  logic        i_RspValid;
  logic [31:0] i_RspData;
  logic        i_PCSrcE;
  logic [31:0] i_PCTargetE;
  logic        i_StallD;
  logic        o_ValidF;
  logic [31:0] o_InstrF;
  logic [31:0] o_PCF;
  logic [31:0] o_PCPlus4F;

  prefetch_fetch_unit #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .o_ReqValid(o_ReqValid), .i_ReqReady(i_ReqReady), .o_ReqAddr(o_ReqAddr),
    .i_RspValid(i_RspValid), .i_RspData(i_RspData),
    .i_PCSrcE(i_PCSrcE), .i_PCTargetE(i_PCTargetE), .i_StallD(i_StallD),
    .o_ValidF(o_ValidF), .o_InstrF(o_InstrF), .o_PCF(o_PCF), .o_PCPlus4F(o_PCPlus4F)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_req_q[$];

  int          n_chk, n_pass, n_fail;
  int          cyc, lat, pop_cnt;
  logic        stall, ready, redir;
  logic [31:0] redir_tgt;
  logic        smp_valid, smp_reqvalid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Program-order expectation after a reset or redirect to start.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    exp_req_q.delete();
    for (int i = 0; i < 64; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    end
    for (int i = 0; i < 3; i++) exp_req_q.push_back(start + 32'(4 * i));
  endtask

  task automatic run_cycle();
    logic         rsp_now, fire;
    fetch_entry_t e;
    @(negedge i_Clk);
    rsp_now    = 1'b0;
    i_RspValid = 1'b0;
    i_RspData  = 32'h0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      rsp_now    = 1'b1;
      i_RspValid = 1'b1;
      i_RspData  = mem_word(pend_q[0].addr);
    end
    i_PCSrcE    = redir;
    i_PCTargetE = redir_tgt;
    i_StallD    = stall;
    i_ReqReady  = ready;
    #1;
    smp_valid    = o_ValidF;
    smp_reqvalid = o_ReqValid;
    fire = o_ReqValid && i_ReqReady;
    if (rsp_now) void'(pend_q.pop_front());
    if (fire) begin
      pend_q.push_back('{addr: o_ReqAddr, due: cyc + lat});
      if (exp_req_q.size() != 0) chk("req_addr", o_ReqAddr, exp_req_q.pop_front());
    end
    if (o_ValidF && !i_StallD && !i_PCSrcE) begin
      pop_cnt++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc", o_PCF, e.pc);
        chk("instr", o_InstrF, e.instr);
        chk("pc_plus4", o_PCPlus4F, e.pc + 32'd4);
      end
    end
    if (redir) load_stream(redir_tgt & ~32'h3);
    @(posedge i_Clk);
    cyc++;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redir     = 1'b1;
    redir_tgt = tgt;
    run_cycle();
    redir = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Reset    = 1'b0;
    i_RspValid = 1'b0;
    i_PCSrcE   = 1'b0;
    redir      = 1'b0;
    pend_q.delete();
    load_stream(RESET_PC);
    #1;
    chk("rst_reqvalid", 32'(o_ReqValid), 32'd0);
    chk("rst_validf", 32'(o_ValidF), 32'd0);
    chk("rst_instr", o_InstrF, NOP);
    chk("rst_pcf", o_PCF, RESET_PC);
    chk("rst_pcplus4", o_PCPlus4F, RESET_PC + 32'd4);
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    #1;
    chk("rst_hold_reqvalid", 32'(o_ReqValid), 32'd0);
    chk("rst_hold_validf", 32'(o_ValidF), 32'd0);
    i_Reset = 1'b1;
    @(posedge i_Clk);
    cyc = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int  p0;
    logic found;
    n_chk = 0; n_pass = 0; n_fail = 0;
    cyc = 0; lat = 1; pop_cnt = 0;
    stall = 1'b0; ready = 1'b1; redir = 1'b0; redir_tgt = 32'h0;
    i_Reset = 1'b1; i_ReqReady = 1'b1; i_RspValid = 1'b0; i_RspData = 32'h0;
    i_PCSrcE = 1'b0; i_PCTargetE = 32'h0; i_StallD = 1'b0;
    #1;

    // Power-on reset, then zero-wait streaming: valid from cycle 3 onward.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      run_cycle();
      chk("validf_startup", 32'(smp_valid), 32'(c >= 3));
    end

    // Decode stall fills the queue and throttles issue; release drains in order.
    stall = 1'b1;
    repeat (10) run_cycle();
    chk("full_reqvalid", 32'(smp_reqvalid), 32'd0);
    chk("full_validf", 32'(smp_valid), 32'd1);
    stall = 1'b0;
    p0 = pop_cnt;
    repeat (4) run_cycle();
    chk("drain_pops", 32'(pop_cnt - p0), 32'd4);
    repeat (4) run_cycle();

    // Misaligned redirect with zero-wait memory: first valid at T+3.
    do_redirect(32'h0000_0202);
    run_cycle();
    chk("redir_t1_validf", 32'(smp_valid), 32'd0);
    run_cycle();
    chk("redir_t2_validf", 32'(smp_valid), 32'd0);
    run_cycle();
    chk("redir_t3_validf", 32'(smp_valid), 32'd1);
    repeat (5) run_cycle();

    // Back-to-back redirects: the later target wins.
    do_redirect(32'h0000_0040);
    do_redirect(32'h0000_0080);
    repeat (8) run_cycle();

    // Address wrap at the top of the space.
    do_redirect(32'hFFFF_FFF8);
    repeat (8) run_cycle();

    // Latency-3 memory: redirect lands on a response cycle with two in flight.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend_q.size() == 2 && pend_q[0].due <= cyc) found = 1'b1;
      else run_cycle();
    end
    chk("lat3_sync_found", 32'(found), 32'd1);
    do_redirect(32'h0000_0100);
    p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == p0; i++) run_cycle();
    chk("lat3_delivery", 32'(pop_cnt > p0), 32'd1);
    repeat (4) run_cycle();

    // Reset while requests are in flight; restart from RESET_PC.
    do_reset();
    p0 = pop_cnt;
    repeat (14) run_cycle();
    chk("post_reset_delivery", 32'(pop_cnt > p0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
